// File: rtl/fpu_seq_if.sv
// rtl/fpu_seq_if.sv - command, fpu-side and response signal bundle for fpu_seq
interface fpu_seq_if #(
    parameter int TAG_W = 4
);
    logic             cmd_v;
    logic             cmd_r;
    logic [1:0]       cmd_opc;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [TAG_W-1:0] cmd_tag;
    logic [1:0]       fpu_opc;
    logic [31:0]      fpu_a;
    logic [31:0]      fpu_b;
    logic             fpu_iv;
    logic             fpu_ir;
    logic             fpu_ov;
    logic             fpu_or;
    logic [31:0]      fpu_y;
    logic             rsp_v;
    logic             rsp_r;
    logic [31:0]      rsp_y;
    logic [1:0]       rsp_opc;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic             busy;

    modport slave (
        input  cmd_v, cmd_opc, cmd_a, cmd_b, cmd_tag, fpu_ir, fpu_ov, fpu_y, rsp_r,
        output cmd_r, fpu_opc, fpu_a, fpu_b, fpu_iv, fpu_or,
               rsp_v, rsp_y, rsp_opc, rsp_tag, rsp_err, busy
    );

    modport master (
        output cmd_v, cmd_opc, cmd_a, cmd_b, cmd_tag, fpu_ir, fpu_ov, fpu_y, rsp_r,
        input  cmd_r, fpu_opc, fpu_a, fpu_b, fpu_iv, fpu_or,
               rsp_v, rsp_y, rsp_opc, rsp_tag, rsp_err, busy
    );
endinterface

// File: rtl/fpu_seq.sv
// rtl/fpu_seq.sv - single-command sequencer in front of fpu; FPU_SEQ_DIV_TMO_EN adds a divide watchdog
module fpu_seq #(
    parameter int TAG_W   = 4,
    parameter int ADD_LAT = 3,
    parameter int MUL_LAT = 3,
    parameter int DIV_TMO = 64
) (
    input  logic       clk,
    input  logic       reset,
    fpu_seq_if.slave   bus
);
    localparam int MAX_LAT = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    if (ADD_LAT < 1 || MUL_LAT < 1 || DIV_TMO < 1) begin : g_bad_param
        $error("fpu_seq: ADD_LAT, MUL_LAT and DIV_TMO must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, WAIT, DIV_REQ, DIV_WAIT, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cmd_r;
    logic             fpu_iv;
    logic             fpu_or;
    logic             rsp_v;
    logic             busy;
    logic [1:0]       fpu_opc;
    logic [31:0]      fpu_a;
    logic [31:0]      fpu_b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      rsp_y;
    logic [1:0]       rsp_opc;
    logic [TAG_W-1:0] rsp_tag;

`ifdef FPU_SEQ_DIV_TMO_EN
    localparam int WD_W = $clog2(DIV_TMO + 1);
    logic [WD_W-1:0] wd;
    logic            wd_fire;
    logic            rsp_err;

    assign wd_fire = (state == DIV_REQ || state == DIV_WAIT) && (wd == WD_W'(DIV_TMO - 1));
    assign bus.rsp_err = rsp_err;
`else
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            cmd_r   <= 1'b0;
            fpu_iv  <= 1'b0;
            fpu_or  <= 1'b0;
            rsp_v   <= 1'b0;
            busy    <= 1'b0;
            fpu_opc <= 2'd0;
            fpu_a   <= 32'd0;
            fpu_b   <= 32'd0;
            tag     <= '0;
            rsp_y   <= 32'd0;
            rsp_opc <= 2'd0;
            rsp_tag <= '0;
`ifdef FPU_SEQ_DIV_TMO_EN
            wd      <= '0;
            rsp_err <= 1'b0;
`endif
        end else begin
            // Divider results that show up outside DIV_WAIT are simply swallowed.
            fpu_or <= 1'b1;
            case (state)
                IDLE: begin
                    cmd_r <= 1'b1;
                    if (bus.cmd_v && cmd_r) begin
                        cmd_r   <= 1'b0;
                        busy    <= 1'b1;
                        fpu_opc <= bus.cmd_opc;
                        fpu_a   <= bus.cmd_a;
                        fpu_b   <= bus.cmd_b;
                        tag     <= bus.cmd_tag;
`ifdef FPU_SEQ_DIV_TMO_EN
                        wd      <= '0;
                        rsp_err <= 1'b0;
`endif
                        case (bus.cmd_opc)
                            2'd0, 2'd1: begin
                                cnt   <= CNT_W'(ADD_LAT);
                                state <= WAIT;
                            end
                            2'd2: begin
                                cnt   <= CNT_W'(MUL_LAT);
                                state <= WAIT;
                            end
                            default: begin
                                fpu_iv <= 1'b1;
                                state  <= DIV_REQ;
                            end
                        endcase
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        rsp_y   <= bus.fpu_y;
                        rsp_opc <= fpu_opc;
                        rsp_tag <= tag;
                        rsp_v   <= 1'b1;
                        state   <= DONE;
                    end
                end
                DIV_REQ: begin
                    if (bus.fpu_ir) begin
                        fpu_iv <= 1'b0;
                        state  <= DIV_WAIT;
                    end
                end
                DIV_WAIT: begin
                    if (bus.fpu_ov) begin
                        rsp_y   <= bus.fpu_y;
                        rsp_opc <= fpu_opc;
                        rsp_tag <= tag;
                        rsp_v   <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.rsp_r) begin
                        rsp_v <= 1'b0;
                        busy  <= 1'b0;
                        cmd_r <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef FPU_SEQ_DIV_TMO_EN
            // A real divider result on the final cycle wins over the timeout.
            if (state == DIV_REQ || state == DIV_WAIT) begin
                wd <= wd + 1'b1;
                if (wd_fire && !(state == DIV_WAIT && bus.fpu_ov)) begin
                    fpu_iv  <= 1'b0;
                    rsp_y   <= 32'h7FC0_0000;
                    rsp_opc <= fpu_opc;
                    rsp_tag <= tag;
                    rsp_err <= 1'b1;
                    rsp_v   <= 1'b1;
                    state   <= DONE;
                end
            end
`endif
        end
    end

    assign bus.cmd_r   = cmd_r;
    assign bus.fpu_opc = fpu_opc;
    assign bus.fpu_a   = fpu_a;
    assign bus.fpu_b   = fpu_b;
    assign bus.fpu_iv  = fpu_iv;
    assign bus.fpu_or  = fpu_or;
    assign bus.rsp_v   = rsp_v;
    assign bus.rsp_y   = rsp_y;
    assign bus.rsp_opc = rsp_opc;
    assign bus.rsp_tag = rsp_tag;
    assign bus.busy    = busy;
endmodule

// File: doc/fpu_seq.md
# fpu_seq

Command sequencer that sits directly upstream of `fpu` and owns its operand, opcode and handshake pins. It accepts one tagged arithmetic command at a time and holds `opc`/`a`/`b` stable for the whole operation, because `fpu` muxes its output on the live opcode. It times the fixed-latency add/sub/mul paths with a counter and runs the divider's valid/ready handshake. Each result is returned on a registered, tagged response port with backpressure.

## Interface
Parameters:
- `TAG_W`, 4: width of the command/response tag.
- `ADD_LAT`, 3: FADD pipeline depth in cycles; must be ≥ 1.
- `MUL_LAT`, 3: FMUL pipeline depth in cycles; must be ≥ 1.
- `DIV_TMO`, 64: divider watchdog limit in cycles; used only with the macro.

Ports:
- `clk` in 1: the only clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cmd_v` in 1 / `cmd_r` out 1: command handshake.
- `cmd_opc` in 2: opcode; 0 = add, 1 = sub, 2 = mul, 3 = div.
- `cmd_a`, `cmd_b` in 32: IEEE-754 single-precision operands.
- `cmd_tag` in TAG_W: tag returned unchanged with the result.
- `fpu_opc` out 2, `fpu_a` out 32, `fpu_b` out 32: registered operands driven to `fpu`.
- `fpu_iv` out 1 / `fpu_ir` in 1: divider input handshake.
- `fpu_ov` in 1 / `fpu_or` out 1: divider output handshake.
- `fpu_y` in 32: result from `fpu`.
- `rsp_v` out 1 / `rsp_r` in 1: response handshake.
- `rsp_y` out 32: result.
- `rsp_opc` out 2: opcode of the completed command.
- `rsp_tag` out TAG_W: tag of the completed command.
- `rsp_err` out 1: set when the divider watchdog fired.
- `busy` out 1: high in any state other than IDLE.

## Operation
States: IDLE, WAIT, DIV_REQ, DIV_WAIT, DONE.
- **IDLE:** `cmd_r`=1. On `cmd_v & cmd_r`:
  - Latch opc, a, b and tag into the `fpu_*` and tag registers.
  - opc 0/1: load `cnt`=ADD_LAT and go to WAIT.
  - opc 2: load `cnt`=MUL_LAT and go to WAIT.
  - opc 3: go to DIV_REQ.
- **WAIT:** `cnt` decrements each cycle. On the edge where `cnt`==1, capture `fpu_y` into `rsp_y` and go to DONE.
- **DIV_REQ:** `fpu_iv`=1. On `fpu_ir`, go to DIV_WAIT.
- **DIV_WAIT:** on `fpu_ov`, capture `fpu_y` and go to DONE.
- **DONE:** `rsp_v`=1. On `rsp_r`, go to IDLE.
- `cmd_r` is 0 in every state except IDLE. Only one command is in flight at a time.
- `fpu_or` is 0 during reset and 1 otherwise. A stray divider result outside DIV_WAIT is therefore consumed and discarded.
- `fpu_*` operand registers keep their value after completion until the next accept.
- Opcode 1 (sub) is passed through unchanged; sign inversion happens downstream.
- `rsp_y`, `rsp_opc`, `rsp_tag` and `rsp_err` are stable while `rsp_v`=1 and `rsp_r`=0.

## Timing
- Reset values:
  - `cmd_r`, `rsp_v`, `fpu_iv`, `fpu_or`, `busy` and `rsp_err` are all 0.
  - All data outputs (`rsp_y`, `rsp_opc`, `rsp_tag`, `fpu_opc`, `fpu_a`, `fpu_b`) are 0.
  - The state is IDLE.
  - `cmd_r` rises in the first cycle after `reset` is deasserted.
- Add/sub/mul latency:
  - Command accepted at edge E0.
  - `fpu_*` are valid from E0 onward.
  - The result is captured at edge E0+LAT.
  - `rsp_v` is high from E0+LAT onward.
- Divide latency:
  - `fpu_iv` rises after E0 and is held until `fpu_ir` is sampled high.
  - The result is captured on the edge where `fpu_ov` is sampled high in DIV_WAIT.
- Minimum command-to-command spacing is LAT+2 cycles (accept, LAT cycles, DONE with `rsp_r`=1, then IDLE).
- `fpu_ov` arriving in the same cycle that `fpu_ir` is accepted is ignored. The result is only valid from DIV_WAIT onward.
- Reset mid-operation:
  - The state returns to IDLE and all outputs take their reset values.
  - The in-flight result and response are dropped.
  - The response is not replayed.

## Configuration
- `FPU_SEQ_DIV_TMO_EN` defined:
  - A watchdog counts cycles spent in DIV_REQ plus DIV_WAIT.
  - On reaching DIV_TMO, go to DONE with `rsp_y`=32'h7FC00000 and `rsp_err`=1.
  - `rsp_err` clears on the next command accept.
- `FPU_SEQ_DIV_TMO_EN` not defined:
  - There is no watchdog logic.
  - A divide waits indefinitely.
  - `rsp_err` is constant 0.

## Test plan
- **Add:** opc 0, a=0x3F800000, b=0x40000000, tag 5 → after ADD_LAT cycles `rsp_y`=0x40400000, `rsp_tag`=5, `rsp_opc`=0.
- **Sub:** opc 1, a=0x40400000, b=0x3F800000 → `rsp_y`=0x40000000. Check `fpu_opc`=1 for the whole operation.
- **Mul under backpressure:** opc 2, a=0x3FC00000, b=0x40000000, with `rsp_r` held 0 for 5 cycles → `rsp_y`=0x40400000 stable, `cmd_r`=0 and `busy`=1 throughout.
- **Divide:** opc 3, a=0x40C00000, b=0x40000000. Model holds `fpu_ir` low for 2 cycles and raises `fpu_ov` after 10 cycles → `fpu_iv` holds until `fpu_ir`, `rsp_y`=0x40400000, `rsp_err`=0.
- **Divide timeout (macro defined, DIV_TMO=8):** opc 3 with `fpu_ov` never asserted → DONE after 8 cycles with `rsp_y`=0x7FC00000 and `rsp_err`=1. The next add clears `rsp_err`.
- **Reset mid-operation:** `reset` pulsed 1 cycle during WAIT of a mul → `rsp_v` never rises, all outputs 0, `cmd_r`=1 the following cycle.
